// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes and handshake FSM state type
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_LESS = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  localparam logic [4:0] OP_REM   = 5'b10110;
  localparam logic [4:0] OP_REMU  = 5'b10111;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one-bit-per-cycle shift-add multiplier and restoring divider
// Ports: clk, rst_n (async active-low), flush (abort), start + op/a/b (load operands);
//   last is high during the final iteration, when res already holds the final value.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mc, half, a_mag, b_mag;
  logic [WIDTH:0] sum, shl, diff;
  logic is_div, sel_hi, neg;
  logic s_div, s_sgn, s_hi, s_neg, a_neg, b_neg;
  assign s_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign s_sgn = op == OP_DIV || op == OP_REM;
  assign s_hi  = op == OP_MULHU || op == OP_REM || op == OP_REMU;
  assign a_neg = s_sgn && a[WIDTH-1];
  assign b_neg = s_sgn && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  // Quotient sign is left alone on divide-by-zero so it stays all ones;
  // the remainder always follows the dividend.
  assign s_neg = s_div && (s_hi ? a_neg : (a_neg ^ b_neg) && |b);
  // acc holds {high product, multiplier} or {partial remainder, dividend/quotient}
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : '0);
  assign shl  = acc[2*WIDTH-1:WIDTH-1];
  assign diff = shl - {1'b0, mc};
  assign acc_n = is_div ? (diff[WIDTH] ? {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                        : {sum, acc[WIDTH-1:1]};
  assign half = sel_hi ? acc_n[2*WIDTH-1:WIDTH] : acc_n[WIDTH-1:0];
  assign res  = neg ? -half : half;
  assign last = cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      mc <= '0;
      is_div <= 1'b0;
      sel_hi <= 1'b0;
      neg <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      acc <= {{WIDTH{1'b0}}, s_div ? a_mag : a};
      mc <= s_div ? b_mag : b;
      is_div <= s_div;
      sel_hi <= s_hi;
      neg <= s_neg;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= acc_n;
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked RV32I ALU with iterative RV32M multiply/divide
// Ports: clk, rst_n (async active-low), flush (sync abort of any op);
//   in_valid/in_ready + op1, op2, alu_op: request, accepted only in IDLE;
//   out_valid/out_ready + result, zero: registered result held until taken.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int EN_MDU = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [4:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int SHAMT_W = $clog2(WIDTH);
  alu_state_t state;
  logic [WIDTH-1:0] base, mdu_res;
  logic [SHAMT_W-1:0] shamt;
  logic is_mul, is_div, accept, mdu_last;
  assign shamt  = op2[SHAMT_W-1:0];
  assign is_mul = EN_MDU != 0 && (alu_op == OP_MUL || alu_op == OP_MULHU);
  assign is_div = EN_MDU != 0 && alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign accept = in_valid && in_ready && !flush;
  // Any bit4 code not taken by the MDU, and any unknown base code, is an ADD.
  always_comb begin
    base = op1 + op2;
    case (alu_op[4] ? OP_ADD : alu_op[3:0])
      OP_SUB:  base = op1 - op2;
      OP_AND:  base = op1 & op2;
      OP_OR:   base = op1 | op2;
      OP_XOR:  base = op1 ^ op2;
      OP_LESS: base = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLL:  base = op1 << shamt;
      OP_SRL:  base = op1 >> shamt;
      OP_SRA:  base = $signed(op1) >>> shamt;
      default: ;
    endcase
  end
  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .start(accept && (is_mul || is_div)),
    .op(alu_op),
    .a(op1),
    .b(op2),
    .last(mdu_last),
    .res(mdu_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      zero <= 1'b0;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (is_mul) state <= MUL;
          else if (is_div) state <= DIV;
          else begin
            state <= DONE;
            result <= base;
            zero <= base == '0;
            out_valid <= 1'b1;
          end
        end
        MUL, DIV: if (mdu_last) begin
          state <= DONE;
          result <= mdu_res;
          zero <= mdu_res == '0;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
